// File: rtl/pwm_pkg.sv
// Shared widths, constants and compare helper for the 16-channel PWM peripheral.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam int unsigned NUM_CH    = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  // Full-scale duty is forced high so 0xFF does not leave a one-tick low stub.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into a one-cycle tick every CLK_DIV cycles.
module pwm_prescaler #(
  parameter int unsigned CLK_DIV = 40
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Turns enable/PWM-select registers and a double-buffered duty into 16 registered pins.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam pwm_cnt_t CNT_MAX = '1;

  logic              tick;
  logic              period_end;
  logic              pwm_hi;
  pwm_cnt_t          pwm_cnt;
  pwm_cnt_t          duty_shadow;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [NUM_CH-1:0] out_next;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign en_out     = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign period_end = tick && (pwm_cnt == CNT_MAX);
  assign pwm_hi     = pwm_compare(pwm_cnt, duty_shadow);

  // PWM-selected channels follow pwm_hi; others are static high when enabled.
  assign out_next = en_out & ~(en_pwm & {NUM_CH{~pwm_hi}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt      <= '0;
      duty_shadow  <= '0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      period_start <= period_end;
      out          <= out_next;
      if (period_end) begin
        pwm_cnt     <= '0;
        duty_shadow <= pwm_duty_cycle;
      end else if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench: a cycle-index model checks two instances (CLK_DIV=1 and 4) every cycle.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en_reg_out_7_0 = '0;
  logic [7:0]  en_reg_out_15_8 = '0;
  logic [7:0]  en_reg_pwm_7_0 = '0;
  logic [7:0]  en_reg_pwm_15_8 = '0;
  logic [7:0]  pwm_duty_cycle = '0;
  logic [15:0] out1, out4;
  logic        ps1, ps4;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .out(out1), .period_start(ps1)
  );

  pwm_peripheral #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .out(out4), .period_start(ps4)
  );

  // Model: after k clock edges since reset, the counter is floor(k/D) mod 256,
  // and a duty load happens on edges where k mod 256*D == 256*D-1.
  int unsigned mk[2];
  logic [7:0]  mshadow[2];
  logic [15:0] exp_out[2];
  logic        exp_ps[2];

  function automatic int unsigned div_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  int unsigned m_div, m_per, m_cnt;
  logic        m_hi, m_load;
  logic [15:0] m_out, m_en_out, m_en_pwm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mk[d]      <= 0;
        mshadow[d] <= '0;
        exp_out[d] <= '0;
        exp_ps[d]  <= 1'b0;
      end
    end else begin
      m_en_out = {en_reg_out_15_8, en_reg_out_7_0};
      m_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      for (int d = 0; d < 2; d++) begin
        m_div  = div_of(d);
        m_per  = 256 * m_div;
        m_cnt  = (mk[d] / m_div) % 256;
        m_hi   = (mshadow[d] == 8'd255) || (m_cnt < int'(mshadow[d]));
        m_load = ((mk[d] % m_per) == m_per - 1);
        for (int ch = 0; ch < 16; ch++)
          m_out[ch] = m_en_out[ch] && (m_en_pwm[ch] ? m_hi : 1'b1);
        exp_out[d] <= m_out;
        exp_ps[d]  <= m_load;
        if (m_load) mshadow[d] <= pwm_duty_cycle;
        mk[d] <= mk[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    n_checks += 2;
    if (out1 !== exp_out[0] || ps1 !== exp_ps[0]) begin
      n_fail++;
      $display("FAIL model_div1 t=%0t out=%h ps=%b expected out=%h ps=%b",
               $time, out1, ps1, exp_out[0], exp_ps[0]);
    end
    if (out4 !== exp_out[1] || ps4 !== exp_ps[1]) begin
      n_fail++;
      $display("FAIL model_div4 t=%0t out=%h ps=%b expected out=%h ps=%b",
               $time, out4, ps4, exp_out[1], exp_ps[1]);
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  // Advances negedges until period_start of the selected instance is seen.
  task automatic wait_ps(input int d, input int unsigned budget, input string name);
    bit seen = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (d == 0) ? ps1 : ps4;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s period_start timeout actual=0 expected=1", name);
    end
  endtask

  // Counts high samples of out1 (all bits) and period_start pulses over n cycles.
  task automatic window(input int unsigned n, output int unsigned hi, output int unsigned pulses,
                        output int unsigned other);
    hi = 0; pulses = 0; other = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (out1 == 16'hFFFF) hi++;
      else if (out1 != 16'h0000) other++;
      if (ps1) pulses++;
    end
  endtask

  int unsigned hi, pulses, other, first_hi;

  initial begin
    // Test 1: reset mid-period while outputs are driven
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pwm_duty_cycle = 8'h80;
    set_en(16'hFFFF, 16'h0000);
    repeat (300) @(negedge clk);
    check("pre_reset_out", out1, 16'hFFFF);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("reset_out", out1, 16'h0000);
    check("reset_ps", ps1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_pwm_cnt", dut.pwm_cnt, 0);
    check("reset_duty_shadow", dut.duty_shadow, 0);

    // Test 2: single static-high channel
    set_en(16'h0001, 16'h0000);
    repeat (2) @(negedge clk);
    check("static_ch0", out1, 16'h0001);
    other = 0;
    for (int unsigned i = 0; i < 512; i++) begin
      @(negedge clk);
      if (out1 != 16'h0001) other++;
    end
    check("static_held_512", other, 0);

    // Test 3: 50% duty on all channels
    pwm_duty_cycle = 8'h80;
    set_en(16'hFFFF, 16'hFFFF);
    wait_ps(0, 600, "duty80");
    first_hi = 0;
    for (int unsigned i = 0; i < 128; i++) begin
      @(negedge clk);
      if (out1 == 16'hFFFF) first_hi++;
    end
    check("duty80_first_half_high", first_hi, 128);
    window(128, hi, pulses, other);
    check("duty80_second_half_high", hi, 0);
    check("duty80_partial_bits", other, 0);

    // Test 4: duty 0 period then duty FF period
    pwm_duty_cycle = 8'h00;
    wait_ps(0, 600, "duty00");
    pwm_duty_cycle = 8'hFF;
    window(256, hi, pulses, other);
    check("duty00_high", hi, 0);
    check("duty00_partial", other, 0);
    window(256, hi, pulses, other);
    check("dutyFF_high", hi, 256);

    // Test 5: change duty 0x40 -> 0xC0 mid-period
    pwm_duty_cycle = 8'h40;
    wait_ps(0, 600, "duty40");
    window(10, hi, pulses, other);
    first_hi = hi;
    pwm_duty_cycle = 8'hC0;
    window(246, hi, pulses, other);
    check("duty40_high", first_hi + hi, 64);
    check("duty40_pulses", pulses, 1);
    window(256, hi, pulses, other);
    check("dutyC0_high", hi, 192);
    check("dutyC0_pulses", pulses, 1);

    // Test 6a: clear a PWM channel's enable mid-high-phase
    pwm_duty_cycle = 8'h80;
    wait_ps(0, 600, "ch3_setup");
    wait_ps(0, 600, "ch3_loaded");
    repeat (5) @(negedge clk);
    check("ch3_before", out1[3], 1);
    set_en(16'hFFF7, 16'hFFFF);
    @(negedge clk);
    check("ch3_disabled", out1[3], 0);
    check("ch2_still_high", out1[2], 1);

    // Test 6b: CLK_DIV=4, duty 1 -> 4-clk pulse per 1024 clk
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h01;
    wait_ps(1, 2100, "div4_setup");
    first_hi = 0; hi = 0; pulses = 0;
    for (int unsigned i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (out4[0]) hi++;
      if (out4[0] && i < 4) first_hi++;
      if (ps4) pulses++;
    end
    check("div4_high_clks", hi, 4);
    check("div4_pulse_at_start", first_hi, 4);
    check("div4_pulses", pulses, 1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
